// File: rtl/mux_seq_pkg.sv
// Shared definitions for the mux select sequencer: FSM state encodings,
// last select value and default rate-divider settings.
package mux_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] SEL_LAST = 3'd6;
  localparam int         DEF_DIV  = 50_000_000;
  localparam int         DEF_CW   = 26;

endpackage

// File: rtl/rate_divider.sv
// Step-rate counter: counts enabled clocks 0..DIV-1 and flags the last one.
// o_tick is decoded from registered state so it clears with async reset.
module rate_divider #(
  parameter int DIV = 50_000_000,
  parameter int CW  = 26
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == LAST);
  assign o_tick    = i_en & w_at_last;

  // Count position within the current select step; wraps at DIV-1.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      if (w_at_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Steps a 7:1 mux select through 0..6, DIV clocks per value, after latching
// a pattern on start. Define SCAN_LOOP_EN to repeat passes until stop.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DIV     = DEF_DIV,
  parameter int CW      = DEF_CW,
  parameter int NUM_SEL = int'(SEL_LAST) + 1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic [6:0] i_pattern,
  output logic [6:0] o_pattern_q,
  output logic [2:0] o_sel,
  output logic       o_tick,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [2:0] LAST = 3'(NUM_SEL - 1);

  state_e     r_state;
  logic [2:0] r_sel;
  logic [6:0] r_pattern_q;
  logic       r_busy;
  logic       r_done;
  logic       w_accept;
  logic       w_abort;
  logic       w_clr;
  logic       w_en;
  logic       w_tick;

  // Decode which control inputs are honoured in the current state.
  always_comb begin
    w_accept = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      ST_IDLE: w_accept = i_start & ~i_stop;
      ST_RUN:  w_abort  = i_stop;
      default: begin
        w_accept = 1'b0;
        w_abort  = 1'b0;
      end
    endcase
    w_clr = w_accept | w_abort;
  end

  assign w_en = (r_state == ST_RUN);

  rate_divider #(
    .DIV (DIV),
    .CW  (CW)
  ) u_rate_divider (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_tick  (w_tick)
  );

  // Sequencer FSM with select, latched pattern and status registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_sel       <= 3'd0;
      r_pattern_q <= 7'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_sel  <= 3'd0;
          if (w_accept) begin
            r_state     <= ST_RUN;
            r_pattern_q <= i_pattern;
            r_busy      <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_sel   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else if (w_tick) begin
            if (r_sel < LAST) begin
              r_sel  <= r_sel + 3'd1;
              r_done <= 1'b0;
            end else begin
`ifdef SCAN_LOOP_EN
              r_sel  <= 3'd0;
              r_done <= 1'b1;
`else
              // sel stays on the last value for the single DONE cycle
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end
          end else begin
            r_done <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_sel   <= 3'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_sel   <= 3'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_pattern_q = r_pattern_q;
  assign o_sel       = r_sel;
  assign o_tick      = w_tick;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench: instance a runs DIV=4, instance b runs DIV=1.
// Expected per-cycle output while busy/done is queued before each start.
module tb_mux_sel_sequencer;

  typedef struct packed {
    logic [2:0] sel;
    logic [6:0] pq;
    logic       tick;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_start = 1'b0, a_stop = 1'b0, b_start = 1'b0, b_stop = 1'b0;
  logic [6:0] a_pattern = 7'd0, b_pattern = 7'd0;
  logic [6:0] a_pq, b_pq;
  logic [2:0] a_sel, b_sel;
  logic       a_tick, a_busy, a_done, b_tick, b_busy, b_done;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mux_sel_sequencer #(.DIV(4), .CW(3), .NUM_SEL(7)) u_a (
    .i_clock(clk), .i_reset(rst), .i_start(a_start), .i_stop(a_stop),
    .i_pattern(a_pattern), .o_pattern_q(a_pq), .o_sel(a_sel),
    .o_tick(a_tick), .o_busy(a_busy), .o_done(a_done));

  mux_sel_sequencer #(.DIV(1), .CW(1), .NUM_SEL(7)) u_b (
    .i_clock(clk), .i_reset(rst), .i_start(b_start), .i_stop(b_stop),
    .i_pattern(b_pattern), .o_pattern_q(b_pq), .o_sel(b_sel),
    .o_tick(b_tick), .o_busy(b_busy), .o_done(b_done));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected trace of one run: ncyc busy cycles, optional trailing DONE cycle.
  task automatic push_items(input bit which, input logic [6:0] p, input int div,
                            input int ncyc, input bit with_done);
    exp_t e;
    for (int c = 0; c < ncyc; c++) begin
      e.pq   = p;
      e.busy = 1'b1;
      e.tick = ((c % div) == (div - 1));
`ifdef SCAN_LOOP_EN
      e.sel  = 3'((c / div) % 7);
      e.done = (c > 0) && ((c % (7 * div)) == 0);
`else
      e.sel  = 3'(c / div);
      e.done = 1'b0;
`endif
      if (which) q_b.push_back(e); else q_a.push_back(e);
    end
    if (with_done) begin
      e.sel = 3'd6; e.pq = p; e.tick = 1'b0; e.busy = 1'b0; e.done = 1'b1;
      if (which) q_b.push_back(e); else q_a.push_back(e);
    end
  endtask

  task automatic start_a(input logic [6:0] p);
    a_pattern = p; a_start = 1'b1; tick_n(1); a_start = 1'b0;
  endtask

  task automatic start_b(input logic [6:0] p);
    b_pattern = p; b_start = 1'b1; tick_n(1); b_start = 1'b0;
  endtask

  // Monitor for instance a.
  always @(negedge clk) begin
    if (!rst && (a_busy || a_done)) begin
      if (q_a.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL a_unexpected: got sel=%0d busy=%b done=%b want no activity at %0t",
                 a_sel, a_busy, a_done, $time);
      end else begin
        ea = q_a.pop_front();
        chk("a_trace", 32'({a_sel, a_pq, a_tick, a_busy, a_done}), 32'(ea));
      end
    end
  end

  // Monitor for instance b.
  always @(negedge clk) begin
    if (!rst && (b_busy || b_done)) begin
      if (q_b.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL b_unexpected: got sel=%0d busy=%b done=%b want no activity at %0t",
                 b_sel, b_busy, b_done, $time);
      end else begin
        eb = q_b.pop_front();
        chk("b_trace", 32'({b_sel, b_pq, b_tick, b_busy, b_done}), 32'(eb));
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel",  32'(a_sel), 32'd0);
    chk("rst_pq",   32'(a_pq), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_tick", 32'(a_tick), 32'd0);
    chk("rst_b",    32'({b_sel, b_pq, b_tick, b_busy, b_done}), 32'd0);
    rst = 1'b0;
    tick_n(2);

`ifdef SCAN_LOOP_EN
    push_items(1'b0, 7'b1010011, 4, 62, 1'b0);
    start_a(7'b1010011);
    tick_n(61);
    a_stop = 1'b1; tick_n(1); a_stop = 1'b0;
    chk("loop_a_busy", 32'(a_busy), 32'd0);
    chk("loop_a_sel",  32'(a_sel), 32'd0);
    chk("loop_a_q",    32'(q_a.size()), 32'd0);
    push_items(1'b1, 7'b0101100, 1, 20, 1'b0);
    start_b(7'b0101100);
    tick_n(19);
    b_stop = 1'b1; tick_n(1); b_stop = 1'b0;
    chk("loop_b_busy", 32'(b_busy), 32'd0);
    chk("loop_b_q",    32'(q_b.size()), 32'd0);
`else
    // Full pass, done at t+29.
    push_items(1'b0, 7'b1010011, 4, 28, 1'b1);
    start_a(7'b1010011);
    tick_n(28);
    tick_n(1);
    chk("s1_busy", 32'(a_busy), 32'd0);
    chk("s1_done", 32'(a_done), 32'd0);
    chk("s1_sel",  32'(a_sel), 32'd0);
    chk("s1_q",    32'(q_a.size()), 32'd0);

    // Restart while sel=2 and again during the DONE cycle: both ignored.
    push_items(1'b0, 7'b1010011, 4, 28, 1'b1);
    start_a(7'b1010011);
    tick_n(9);
    a_pattern = 7'h7F; a_start = 1'b1; tick_n(1); a_start = 1'b0;
    tick_n(18);
    a_start = 1'b1; tick_n(1); a_start = 1'b0;
    chk("s2_busy", 32'(a_busy), 32'd0);
    chk("s2_pq",   32'(a_pq), 32'h53);
    chk("s2_q",    32'(q_a.size()), 32'd0);
    tick_n(2);

    // Stop while sel=3.
    push_items(1'b0, 7'b0110101, 4, 14, 1'b0);
    start_a(7'b0110101);
    tick_n(13);
    a_stop = 1'b1; tick_n(1); a_stop = 1'b0;
    chk("s3_busy", 32'(a_busy), 32'd0);
    chk("s3_sel",  32'(a_sel), 32'd0);
    chk("s3_done", 32'(a_done), 32'd0);
    tick_n(40);
    chk("s3_q",    32'(q_a.size()), 32'd0);

    // Asynchronous reset on the last cycle of the sel=5 step.
    push_items(1'b0, 7'b1100110, 4, 28, 1'b1);
    start_a(7'b1100110);
    tick_n(23);
    chk("s4_pre", 32'({a_sel, a_tick}), 32'({3'd5, 1'b1}));
    #1 rst = 1'b1;
    #1;
    chk("s4_rst", 32'({a_sel, a_pq, a_tick, a_busy, a_done}), 32'd0);
    q_a.delete();
    #1 rst = 1'b0;
    push_items(1'b0, 7'b0011001, 4, 28, 1'b1);
    start_a(7'b0011001);
    tick_n(29);
    chk("s4_busy", 32'(a_busy), 32'd0);
    chk("s4_q",    32'(q_a.size()), 32'd0);

    // DIV=1: sel advances every clock, done at t+8.
    push_items(1'b1, 7'b1001110, 1, 7, 1'b1);
    start_b(7'b1001110);
    tick_n(7);
    chk("s5_done", 32'(b_done), 32'd1);
    tick_n(1);
    chk("s5_busy", 32'(b_busy), 32'd0);
    chk("s5_q",    32'(q_b.size()), 32'd0);
`endif

    // start and stop together in IDLE: stop wins.
    b_pattern = 7'h2A; b_start = 1'b1; b_stop = 1'b1;
    tick_n(1);
    b_start = 1'b0; b_stop = 1'b0;
    chk("ss_busy", 32'(b_busy), 32'd0);
    tick_n(4);
    chk("ss_q",    32'(q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
